// File: rtl/mips_imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_imem_pkg
//  Description : Shared types and constants for the MIPS instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_imem_pkg;

    typedef enum logic [0:0] {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/imem_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_ram
//  Description : Byte array with one synchronous write port and four
//                combinational byte-read ports at rd_addr..rd_addr+3.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_byte_ram
    import mips_imem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data0,
    output logic [7:0]        rd_data1,
    output logic [7:0]        rd_data2,
    output logic [7:0]        rd_data3
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [7:0]      mem_q  [DEPTH];
    logic [7:0]      rd_b   [WORD_BYTES];
    logic [ADDR_W:0] rd_idx [WORD_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < DEPTH_C)) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Reads past the end return zero; the caller flags such fetches anyway.
    always_comb begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_idx[k] = {1'b0, rd_addr} + (ADDR_W + 1)'(k);
            rd_b[k]   = (rd_idx[k] < DEPTH_C) ? mem_q[rd_idx[k][IDX_W-1:0]] : 8'h00;
        end
    end

    assign rd_data0 = rd_b[0];
    assign rd_data1 = rd_b[1];
    assign rd_data2 = rd_b[2];
    assign rd_data3 = rd_b[3];

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Byte-serial loadable instruction memory with a registered,
//                stallable, bounds-checked big-endian fetch port.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import mips_imem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int BOOT_RUN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_valid,
    input  logic [7:0]        prog_byte,
    input  logic              prog_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              fault,
    output logic              loading,
    output logic [ADDR_W:0]   prog_count,
    output logic              prog_overflow
);

    localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_WORD_C = (ADDR_W + 1)'(DEPTH - WORD_BYTES);
    localparam imem_state_e     RESET_STATE = (BOOT_RUN != 0) ? IMEM_RUN : IMEM_LOAD;

    imem_state_e     state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fault_q, fault_d;
    logic [ADDR_W:0] prog_count_q, prog_count_d;
    logic            prog_overflow_q, prog_overflow_d;

    logic            wr_en;
    logic            bad_addr;
    logic [7:0]      rd0, rd1, rd2, rd3;

    imem_byte_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (prog_count_q),
        .wr_data  (prog_byte),
        .rd_addr  (pc),
        .rd_data0 (rd0),
        .rd_data1 (rd1),
        .rd_data2 (rd2),
        .rd_data3 (rd3)
    );

    assign bad_addr = (pc[1:0] != 2'b00) || ({1'b0, pc} > LAST_WORD_C);

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        instr_valid_d   = instr_valid_q;
        fault_d         = fault_q;
        prog_count_d    = prog_count_q;
        prog_overflow_d = prog_overflow_q;
        wr_en           = 1'b0;

        case (state_q)
            IMEM_LOAD: begin
                instr_valid_d = 1'b0;
                if (prog_valid) begin
                    if (prog_count_q < DEPTH_C) begin
                        wr_en        = 1'b1;
                        prog_count_d = prog_count_q + 1'b1;
                    end else begin
                        prog_overflow_d = 1'b1;
                    end
                end
                if (prog_done) begin
                    state_d = IMEM_RUN;
                end
            end
            IMEM_RUN: begin
                // A stall freezes every fetch output register.
                if (!stall) begin
                    if (fetch_req) begin
                        instr_valid_d = 1'b1;
                        fault_d       = bad_addr;
                        instr_d       = bad_addr ? NOP_INSTR : {rd0, rd1, rd2, rd3};
                    end else begin
                        instr_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RESET_STATE;
            instr_q         <= NOP_INSTR;
            instr_valid_q   <= 1'b0;
            fault_q         <= 1'b0;
            prog_count_q    <= '0;
            prog_overflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            instr_q         <= instr_d;
            instr_valid_q   <= instr_valid_d;
            fault_q         <= fault_d;
            prog_count_q    <= prog_count_d;
            prog_overflow_q <= prog_overflow_d;
        end
    end

    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign fault         = fault_q;
    assign loading       = (state_q == IMEM_LOAD);
    assign prog_count    = prog_count_q;
    assign prog_overflow = prog_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Scoreboard bench for instr_mem_loader (256-byte and 16-byte).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       prog_valid, prog_done, fetch_req, stall;
    logic [7:0] prog_byte, pc;
    logic [31:0] instr_a;
    logic       instr_valid_a, fault_a, loading_a, prog_overflow_a;
    logic [8:0] prog_count_a;

    logic       b_prog_valid, b_prog_done, b_fetch_req, b_stall;
    logic [7:0] b_prog_byte, b_pc;
    logic [31:0] instr_b;
    logic       instr_valid_b, fault_b, loading_b, prog_overflow_b;
    logic [8:0] prog_count_b;

    int   checks   = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    instr_mem_loader #(.ADDR_W(8), .DEPTH(256), .BOOT_RUN(0)) u_dut_a (
        .clk(clk), .rst(rst), .prog_valid(prog_valid), .prog_byte(prog_byte),
        .prog_done(prog_done), .fetch_req(fetch_req), .pc(pc), .stall(stall),
        .instr(instr_a), .instr_valid(instr_valid_a), .fault(fault_a),
        .loading(loading_a), .prog_count(prog_count_a), .prog_overflow(prog_overflow_a)
    );

    instr_mem_loader #(.ADDR_W(8), .DEPTH(16), .BOOT_RUN(0)) u_dut_b (
        .clk(clk), .rst(rst), .prog_valid(b_prog_valid), .prog_byte(b_prog_byte),
        .prog_done(b_prog_done), .fetch_req(b_fetch_req), .pc(b_pc), .stall(b_stall),
        .instr(instr_b), .instr_valid(instr_valid_b), .fault(fault_b),
        .loading(loading_b), .prog_count(prog_count_b), .prog_overflow(prog_overflow_b)
    );

    // Monitors: every cycle an output is presented, it must match the next expectation.
    always @(negedge clk) begin
        if (instr_valid_a) begin
            checks++;
            if (q_a.size() == 0) begin
                failures++;
                $display("FAIL fetch_a unexpected instr_valid actual=%h required=none", instr_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if (instr_a !== e.instr || fault_a !== e.fault) begin
                    failures++;
                    $display("FAIL fetch_a actual instr=%h fault=%b required instr=%h fault=%b",
                             instr_a, fault_a, e.instr, e.fault);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (instr_valid_b) begin
            checks++;
            if (q_b.size() == 0) begin
                failures++;
                $display("FAIL fetch_b unexpected instr_valid actual=%h required=none", instr_b);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                if (instr_b !== e.instr || fault_b !== e.fault) begin
                    failures++;
                    $display("FAIL fetch_b actual instr=%h fault=%b required instr=%h fault=%b",
                             instr_b, fault_b, e.instr, e.fault);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic load_a(input logic [7:0] b);
        prog_valid = 1'b1;
        prog_byte  = b;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] b);
        b_prog_valid = 1'b1;
        b_prog_byte  = b;
        tick();
        b_prog_valid = 1'b0;
    endtask

    task automatic fetch_a(input logic [7:0] addr, input logic [31:0] ei, input logic ef);
        fetch_req = 1'b1;
        pc        = addr;
        q_a.push_back('{instr: ei, fault: ef});
        tick();
    endtask

    task automatic fetch_b(input logic [7:0] addr, input logic [31:0] ei, input logic ef);
        b_fetch_req = 1'b1;
        b_pc        = addr;
        q_b.push_back('{instr: ei, fault: ef});
        tick();
    endtask

    logic [7:0] prog_bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};

    initial begin
        rst = 1'b1;
        prog_valid = 1'b0; prog_done = 1'b0; fetch_req = 1'b0; stall = 1'b0;
        prog_byte = 8'h00; pc = 8'h00;
        b_prog_valid = 1'b0; b_prog_done = 1'b0; b_fetch_req = 1'b0; b_stall = 1'b0;
        b_prog_byte = 8'h00; b_pc = 8'h00;
        tick();
        tick();

        check("rst_instr",       instr_a,         0);
        check("rst_instr_valid", instr_valid_a,   0);
        check("rst_fault",       fault_a,         0);
        check("rst_prog_count",  prog_count_a,    0);
        check("rst_overflow",    prog_overflow_a, 0);
        check("rst_loading",     loading_a,       1);
        check("rst_loading_b",   loading_b,       1);
        rst = 1'b0;

        // Overflow on the 16-byte memory: byte 17 must be dropped.
        for (int i = 0; i < 16; i++) load_b(8'h10 + 8'(i));
        check("b_count_full",    prog_count_b,    16);
        check("b_overflow_pre",  prog_overflow_b, 0);
        load_b(8'hEE);
        check("b_count_hold",    prog_count_b,    16);
        check("b_overflow_post", prog_overflow_b, 1);
        b_prog_done = 1'b1;
        tick();
        b_prog_done = 1'b0;
        check("b_loading_run",   loading_b,       0);
        fetch_b(8'd0,  32'h10111213, 1'b0);
        fetch_b(8'd12, 32'h1C1D1E1F, 1'b0);
        fetch_b(8'd16, 32'h00000000, 1'b1);
        b_fetch_req = 1'b0;
        tick();

        // Load then fetch back-to-back.
        for (int i = 0; i < 8; i++) load_a(prog_bytes[i]);
        check("a_count_8", prog_count_a, 8);
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        check("a_loading_run", loading_a, 0);
        prog_valid = 1'b1; prog_byte = 8'hFF;
        tick();
        prog_valid = 1'b0;
        check("a_count_run_ignored", prog_count_a, 8);
        fetch_a(8'd0, 32'h20080005, 1'b0);
        fetch_a(8'd4, 32'h20090007, 1'b0);
        fetch_req = 1'b0;
        tick();
        check("a_valid_drop", instr_valid_a, 0);
        check("a_instr_hold", instr_a, 32'h20090007);

        // Misaligned and out of range.
        fetch_a(8'd1,   32'h00000000, 1'b1);
        fetch_a(8'd254, 32'h00000000, 1'b1);
        fetch_req = 1'b0;
        tick();

        // Stall hold: three cycles of the same word, then the next one.
        fetch_a(8'd0, 32'h20080005, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) fetch_a(8'd4, 32'h20080005, 1'b0);
        stall = 1'b0;
        fetch_a(8'd4, 32'h20090007, 1'b0);
        fetch_req = 1'b0;
        tick();

        // Reset with a fetch pending.
        fetch_a(8'd0, 32'h20080005, 1'b0);
        rst = 1'b1; pc = 8'd4;
        tick();
        fetch_req = 1'b0;
        check("rstf_instr",   instr_a,       0);
        check("rstf_valid",   instr_valid_a, 0);
        check("rstf_loading", loading_a,     1);
        check("rstf_count",   prog_count_a,  0);
        rst = 1'b0;

        // Reset mid-load with a fetch request present.
        for (int i = 0; i < 5; i++) load_a(8'h55);
        check("rstl_count_pre", prog_count_a, 5);
        rst = 1'b1; prog_valid = 1'b1; fetch_req = 1'b1;
        tick();
        rst = 1'b0; prog_valid = 1'b0; fetch_req = 1'b0;
        check("rstl_count",   prog_count_a,  0);
        check("rstl_loading", loading_a,     1);
        check("rstl_valid",   instr_valid_a, 0);
        check("rstl_instr",   instr_a,       0);

        // Simultaneous write and done at count 3.
        load_a(8'h11);
        load_a(8'h22);
        load_a(8'h33);
        prog_valid = 1'b1; prog_byte = 8'hAB; prog_done = 1'b1;
        tick();
        prog_valid = 1'b0; prog_done = 1'b0;
        check("simul_loading", loading_a,    0);
        check("simul_count",   prog_count_a, 4);
        fetch_a(8'd0, 32'h112233AB, 1'b0);
        fetch_req = 1'b0;
        tick();
        tick();

        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
